obuf_quant_writer: RTL and testbench

Parametrised write-back stage between the PE array's accumulator output and the output SRAM macro. It replaces the fixed per-channel bit-slice repacking with configurable requantisation: shift, optional round, optional ReLU and saturation. Quantised words are buffered in a small FIFO and written to the output memory, which may stall the writes. Burst start address, burst length, address wrap and completion are handled in hardware.

---
 rtl/obuf_quant_writer.sv | 167 ++++++++++++++++
 tb/tb_obuf_quant_writer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obuf_quant_writer.sv
// obuf_quant_writer: requantises accumulator beats (shift, optional round,
// ReLU, saturate), buffers them in a small first-word-fall-through FIFO and
// writes them to the output SRAM as an address-incrementing burst.
module obuf_quant_writer #(
    parameter int NUM_CH      = 8,
    parameter int ACCU_WIDTH  = 16,
    parameter int OUT_WIDTH   = 8,
    parameter int SHIFT_WIDTH = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int ADDR_WIDTH  = 10,
    parameter int MEM_WIDTH   = NUM_CH * OUT_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         start,
    input  logic [SHIFT_WIDTH-1:0]       cfg_shift,
    input  logic                         cfg_round,
    input  logic                         cfg_relu,
    input  logic [ADDR_WIDTH-1:0]        cfg_base_addr,
    input  logic [ADDR_WIDTH-1:0]        cfg_num_words,
    input  logic                         in_valid,
    input  logic [NUM_CH*ACCU_WIDTH-1:0] in_data,
    output logic                         in_ready,
    input  logic                         mem_ready,
    output logic                         mem_wen,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [MEM_WIDTH-1:0]         mem_data,
    output logic                         busy,
    output logic                         done,
    output logic                         sat_flag
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    // Saturation bounds expressed in the widened (ACCU_WIDTH+1) domain.
    localparam logic signed [ACCU_WIDTH:0] SAT_HI =
        $signed({{(ACCU_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
    localparam logic signed [ACCU_WIDTH:0] SAT_LO =
        $signed({{(ACCU_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}});
    localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                  r_state, w_state_next;
    logic [SHIFT_WIDTH-1:0]  r_shift;
    logic                    r_round, r_relu, r_sat;
    logic [ADDR_WIDTH-1:0]   r_num_words, r_count, r_addr;
    logic                    r_q_valid;
    logic [MEM_WIDTH-1:0]    r_q_data;
    logic [MEM_WIDTH-1:0]    r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]        r_fifo_count;

    logic                    w_fifo_nonempty, w_push, w_pop, w_accept, w_start_accept;
    logic [MEM_WIDTH-1:0]    w_q_word;
    logic [NUM_CH-1:0]       w_sat_ch;

    // Per-channel requantisation datapath driven by the shadow config.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic signed [ACCU_WIDTH:0] w_bias, w_x, w_y, w_r;
            logic                       w_hi, w_lo;
            // Round half-up bias is only meaningful for a non-zero shift.
            assign w_bias = (r_round && (r_shift != '0))
                          ? ({{ACCU_WIDTH{1'b0}}, 1'b1} << (r_shift - SHIFT_WIDTH'(1)))
                          : '0;
            // One extra bit of headroom so the bias never wraps.
            assign w_x = {in_data[gi*ACCU_WIDTH + ACCU_WIDTH - 1],
                          in_data[gi*ACCU_WIDTH +: ACCU_WIDTH]} + w_bias;
            assign w_y = w_x >>> r_shift;
            assign w_r = (r_relu && w_y[ACCU_WIDTH]) ? '0 : w_y;
            assign w_hi = (w_r > SAT_HI);
            assign w_lo = (w_r < SAT_LO);
            assign w_q_word[gi*OUT_WIDTH +: OUT_WIDTH] =
                w_hi ? OUT_MAX : (w_lo ? OUT_MIN : w_r[OUT_WIDTH-1:0]);
            assign w_sat_ch[gi] = w_hi | w_lo;
        end
    endgenerate

    // Handshakes. The Q stage is counted against FIFO space so its push on
    // the following edge can never find the FIFO full.
    assign w_fifo_nonempty = (r_fifo_count != '0);
    assign in_ready = enable && (r_state == S_RUN) && (r_count < r_num_words) &&
                      (({1'b0, r_fifo_count} + (CNT_W+1)'(r_q_valid)) < (CNT_W+1)'(FIFO_DEPTH));
    assign w_accept       = in_valid && in_ready;
    assign w_push         = enable && r_q_valid;
    assign w_pop          = enable && w_fifo_nonempty && mem_ready;
    assign w_start_accept = (r_state == S_IDLE) && start;

    assign mem_wen  = ~(w_fifo_nonempty & enable);
    assign mem_addr = r_addr;
    assign mem_data = w_fifo_nonempty ? r_fifo_mem[r_rd_ptr] : '0;
    assign busy     = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done     = (r_state == S_DONE);
    assign sat_flag = r_sat;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic; nothing moves while enable is low.
    always_comb begin
        w_state_next = r_state;
        if (enable) begin
            case (r_state)
                S_IDLE:  if (start) w_state_next = S_RUN;
                S_RUN:   if (r_count == r_num_words) w_state_next = S_DRAIN;
                S_DRAIN: if (!r_q_valid && !w_fifo_nonempty) w_state_next = S_DONE;
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Config shadows, burst counters, Q stage and FIFO pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift      <= '0;
            r_round      <= 1'b0;
            r_relu       <= 1'b0;
            r_num_words  <= '0;
            r_count      <= '0;
            r_addr       <= '0;
            r_sat        <= 1'b0;
            r_q_valid    <= 1'b0;
            r_q_data     <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
        end else if (enable) begin
            if (w_start_accept) begin
                r_shift     <= cfg_shift;
                r_round     <= cfg_round;
                r_relu      <= cfg_relu;
                r_num_words <= cfg_num_words;
                r_addr      <= cfg_base_addr;
                r_count     <= '0;
                r_sat       <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_count <= r_count + ADDR_WIDTH'(1);
                    if (|w_sat_ch) r_sat <= 1'b1;
                end
                if (w_pop) r_addr <= r_addr + ADDR_WIDTH'(1);
            end
            r_q_valid <= w_accept;
            if (w_accept) r_q_data <= w_q_word;
            if (w_push)
                r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH-1)) ? '0 : r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH-1)) ? '0 : r_rd_ptr + PTR_W'(1);
            r_fifo_count <= r_fifo_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // FIFO storage; the head is read combinationally for fall-through.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo_mem[r_wr_ptr] <= r_q_data;
    end

endmodule

// File: tb/tb_obuf_quant_writer.sv
// tb_obuf_quant_writer: directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_obuf_quant_writer;

    localparam int NUM_CH = 8, ACCU_WIDTH = 16, OUT_WIDTH = 8;
    localparam int SHIFT_WIDTH = 4, FIFO_DEPTH = 4, ADDR_WIDTH = 10;
    localparam int MEM_WIDTH = NUM_CH * OUT_WIDTH;

    logic                         clk = 1'b0;
    logic                         reset = 1'b1;
    logic                         enable = 1'b1;
    logic                         start = 1'b0;
    logic [SHIFT_WIDTH-1:0]       cfg_shift = '0;
    logic                         cfg_round = 1'b0;
    logic                         cfg_relu = 1'b0;
    logic [ADDR_WIDTH-1:0]        cfg_base_addr = '0;
    logic [ADDR_WIDTH-1:0]        cfg_num_words = '0;
    logic                         in_valid = 1'b0;
    logic [NUM_CH*ACCU_WIDTH-1:0] in_data = '0;
    logic                         in_ready;
    logic                         mem_ready = 1'b1;
    logic                         mem_wen;
    logic [ADDR_WIDTH-1:0]        mem_addr;
    logic [MEM_WIDTH-1:0]         mem_data;
    logic                         busy, done, sat_flag;

    int tests = 0;
    int fails = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    logic [ADDR_WIDTH-1:0] wr_addr_q[$];
    logic [MEM_WIDTH-1:0]  wr_data_q[$];

    obuf_quant_writer #(
        .NUM_CH(NUM_CH), .ACCU_WIDTH(ACCU_WIDTH), .OUT_WIDTH(OUT_WIDTH),
        .SHIFT_WIDTH(SHIFT_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start),
        .cfg_shift(cfg_shift), .cfg_round(cfg_round), .cfg_relu(cfg_relu),
        .cfg_base_addr(cfg_base_addr), .cfg_num_words(cfg_num_words),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_ready(mem_ready), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_data(mem_data), .busy(busy), .done(done), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    // Capture: inputs settle 1ns after posedge, so the negedge view is what
    // the next posedge will act on.
    always @(negedge clk) begin
        if (!reset) begin
            if (in_valid && in_ready) acc_cnt++;
            if (!mem_wen && mem_ready) begin
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_data);
                $display("[TB] write addr=%03h data=%016h", mem_addr, mem_data);
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_capture();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic start_burst(input logic [3:0] sh, input logic rnd, input logic rl,
                               input logic [9:0] base, input logic [9:0] n);
        cfg_shift = sh; cfg_round = rnd; cfg_relu = rl;
        cfg_base_addr = base; cfg_num_words = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        // Later config changes must not matter.
        cfg_shift = 4'hF; cfg_base_addr = 10'h2AA; cfg_num_words = 10'd1;
    endtask

    // Offer one beat until accepted (bounded).
    task automatic send_beat(input logic [127:0] beat, output bit ok);
        bit acc;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = beat;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) begin ok = 1'b1; break; end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        int d0;
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (done_cnt > d0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        tests++; if (mem_wen !== 1'b1) begin fails++; $display("FAIL reset_mem_wen got %b want 1", mem_wen); end
        tests++; if (mem_addr !== 10'h000) begin fails++; $display("FAIL reset_mem_addr got %h want 000", mem_addr); end
        tests++; if (mem_data !== 64'h0) begin fails++; $display("FAIL reset_mem_data got %h want 0", mem_data); end
        tests++; if ({busy, done, sat_flag} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {busy, done, sat_flag}); end
        reset = 1'b0;
        tick();
        $display("[TB] reset checked");
    endtask

    task automatic test_basic_write();
        logic [15:0] vals[3] = '{16'h1234, 16'h0100, 16'hFF00};
        logic [7:0]  exp[3]  = '{8'h12, 8'h01, 8'hFF};
        bit ok;
        int d0;
        clear_capture();
        mem_ready = 1'b1;
        d0 = done_cnt;
        start_burst(4'd8, 1'b0, 1'b0, 10'h010, 10'd3);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy got %b want 1", busy); end
        for (int i = 0; i < 3; i++) begin
            send_beat({112'h0, vals[i]}, ok);
            tests++; if (!ok) begin fails++; $display("FAIL basic_accept beat %0d got timeout want accepted", i); end
        end
        wait_done(40, ok);
        repeat (3) tick();
        tests++; if (wr_addr_q.size() != 3) begin fails++; $display("FAIL basic_count got %0d want 3", wr_addr_q.size()); end
        for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
            tests++; if (wr_addr_q[i] !== 10'h010 + 10'(i)) begin fails++; $display("FAIL basic_addr %0d got %h want %h", i, wr_addr_q[i], 10'h010 + 10'(i)); end
            tests++; if (wr_data_q[i] !== {56'h0, exp[i]}) begin fails++; $display("FAIL basic_data %0d got %h want %h", i, wr_data_q[i], {56'h0, exp[i]}); end
        end
        tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt - d0); end
        tests++; if (sat_flag !== 1'b0) begin fails++; $display("FAIL basic_sat got %b want 0", sat_flag); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_round_relu_sat();
        logic [15:0] vals[3] = '{16'h0018, 16'h7FF0, 16'h8000};
        logic [7:0]  exp[3]  = '{8'h02, 8'h7F, 8'h80};
        bit ok;
        clear_capture();
        start_burst(4'd4, 1'b1, 1'b0, 10'h040, 10'd3);
        for (int i = 0; i < 3; i++) send_beat({112'h0, vals[i]}, ok);
        wait_done(40, ok);
        tests++; if (!ok) begin fails++; $display("FAIL rnd_done got timeout want done"); end
        tests++; if (wr_data_q.size() != 3) begin fails++; $display("FAIL rnd_count got %0d want 3", wr_data_q.size()); end
        for (int i = 0; i < 3 && i < wr_data_q.size(); i++) begin
            tests++; if (wr_data_q[i] !== {56'h0, exp[i]}) begin fails++; $display("FAIL rnd_data %0d got %h want %h", i, wr_data_q[i], {56'h0, exp[i]}); end
        end
        tests++; if (sat_flag !== 1'b1) begin fails++; $display("FAIL rnd_sat got %b want 1", sat_flag); end
        // ReLU burst: ch0 = -16 -> 0, ch1 = 0x0018 -> 2; start clears the sticky flag.
        clear_capture();
        start_burst(4'd4, 1'b1, 1'b1, 10'h050, 10'd1);
        tests++; if (sat_flag !== 1'b0) begin fails++; $display("FAIL relu_sat_clear got %b want 0", sat_flag); end
        send_beat({96'h0, 16'h0018, 16'hFFF0}, ok);
        wait_done(40, ok);
        tests++; if (wr_data_q.size() != 1) begin fails++; $display("FAIL relu_count got %0d want 1", wr_data_q.size()); end
        else begin
            tests++; if (wr_data_q[0] !== 64'h0000_0000_0000_0200) begin fails++; $display("FAIL relu_data got %h want 0000000000000200", wr_data_q[0]); end
        end
        tests++; if (sat_flag !== 1'b0) begin fails++; $display("FAIL relu_sat got %b want 0", sat_flag); end
    endtask

    task automatic test_backpressure();
        int idx, low, phase, d0;
        bit acc;
        clear_capture();
        mem_ready = 1'b1;
        d0 = done_cnt;
        idx = 0; low = 0; phase = 0;
        start_burst(4'd0, 1'b0, 1'b0, 10'h100, 10'd8);
        for (int cyc = 0; cyc < 200; cyc++) begin
            in_valid = (idx < 8);
            in_data  = {120'h0, 8'(idx + 1)};
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
            if (phase == 0 && wr_addr_q.size() >= 1) begin
                mem_ready = 1'b0; phase = 1;
            end else if (phase == 1) begin
                low++;
                if (low == 10) begin
                    tests++; if (idx != FIFO_DEPTH + 1) begin fails++; $display("FAIL bp_accepted got %0d want %0d", idx, FIFO_DEPTH + 1); end
                    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
                    tests++; if (wr_addr_q.size() != 1) begin fails++; $display("FAIL bp_stalled_writes got %0d want 1", wr_addr_q.size()); end
                    mem_ready = 1'b1; phase = 2;
                end
            end
            if (done_cnt > d0) break;
        end
        in_valid = 1'b0;
        tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL bp_done got %0d want 1", done_cnt - d0); end
        tests++; if (wr_addr_q.size() != 8) begin fails++; $display("FAIL bp_count got %0d want 8", wr_addr_q.size()); end
        for (int i = 0; i < 8 && i < wr_addr_q.size(); i++) begin
            if (wr_addr_q[i] !== 10'h100 + 10'(i) || wr_data_q[i] !== {56'h0, 8'(i + 1)}) begin
                tests++; fails++;
                $display("FAIL bp_word %0d got %h/%h want %h/%h", i, wr_addr_q[i], wr_data_q[i], 10'h100 + 10'(i), {56'h0, 8'(i + 1)});
            end else tests++;
        end
    endtask

    task automatic test_wrap_freeze();
        logic [9:0] exp_a[4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        logic [7:0] vals[4]  = '{8'h11, 8'h22, 8'h33, 8'h44};
        int idx, d0, nw;
        bit acc;
        clear_capture();
        mem_ready = 1'b1;
        d0 = done_cnt;
        idx = 0;
        start_burst(4'd0, 1'b0, 1'b0, 10'h3FE, 10'd4);
        for (int cyc = 0; cyc < 100; cyc++) begin
            enable   = !(cyc >= 2 && cyc < 5);
            in_valid = (idx < 4);
            in_data  = {120'h0, (idx < 4) ? vals[idx] : 8'h00};
            nw = wr_addr_q.size();
            @(negedge clk);
            acc = in_valid && in_ready;
            if (!enable) begin
                tests++; if (mem_wen !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
                    fails++; $display("FAIL freeze_cycle %0d got wen=%b rdy=%b busy=%b want 1/0/1", cyc, mem_wen, in_ready, busy);
                end
                tests++; if (wr_addr_q.size() != nw) begin fails++; $display("FAIL freeze_write %0d got %0d want %0d", cyc, wr_addr_q.size(), nw); end
            end
            tick();
            if (acc) idx++;
            if (done_cnt > d0) break;
        end
        enable = 1'b1;
        in_valid = 1'b0;
        tests++; if (wr_addr_q.size() != 4) begin fails++; $display("FAIL wrap_count got %0d want 4", wr_addr_q.size()); end
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            tests++; if (wr_addr_q[i] !== exp_a[i] || wr_data_q[i] !== {56'h0, vals[i]}) begin
                fails++; $display("FAIL wrap_word %0d got %h/%h want %h/%h", i, wr_addr_q[i], wr_data_q[i], exp_a[i], {56'h0, vals[i]});
            end
        end
    endtask

    task automatic test_boundary();
        bit ok;
        // Zero-length burst: done in cycle c+3, no writes, no accepts.
        clear_capture();
        acc_cnt = 0;
        in_valid = 1'b1;
        in_data = {112'h0, 16'h1111};
        start_burst(4'd0, 1'b0, 1'b0, 10'h123, 10'd0);   // now in c+1
        tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL zero_c1 got busy=%b done=%b want 1/0", busy, done); end
        tick();
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL zero_c2 got done=%b want 0", done); end
        tick();
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL zero_c3 got done=%b want 1", done); end
        tick();
        tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL zero_c4 got done=%b busy=%b want 0/0", done, busy); end
        tests++; if (wr_addr_q.size() != 0 || acc_cnt != 0) begin fails++; $display("FAIL zero_traffic got writes=%0d accepts=%0d want 0/0", wr_addr_q.size(), acc_cnt); end
        in_valid = 1'b0;

        // start during RUN is ignored.
        clear_capture();
        start_burst(4'd0, 1'b0, 1'b0, 10'h020, 10'd2);
        tick();
        cfg_base_addr = 10'h055; cfg_num_words = 10'd1; start = 1'b1;
        tick();
        start = 1'b0;
        send_beat({112'h0, 16'h0005}, ok);
        send_beat({112'h0, 16'h0006}, ok);
        wait_done(40, ok);
        tests++; if (wr_addr_q.size() != 2) begin fails++; $display("FAIL restart_count got %0d want 2", wr_addr_q.size()); end
        else begin
            tests++; if (wr_addr_q[0] !== 10'h020 || wr_addr_q[1] !== 10'h021) begin
                fails++; $display("FAIL restart_addr got %h,%h want 020,021", wr_addr_q[0], wr_addr_q[1]);
            end
        end

        // Reset in DRAIN discards buffered words.
        clear_capture();
        mem_ready = 1'b0;
        start_burst(4'd0, 1'b0, 1'b0, 10'h030, 10'd2);
        send_beat({112'h0, 16'h0007}, ok);
        send_beat({112'h0, 16'h0008}, ok);
        tick();
        tests++; if (busy !== 1'b1 || in_ready !== 1'b0 || mem_wen !== 1'b0) begin
            fails++; $display("FAIL drain_state got busy=%b rdy=%b wen=%b want 1/0/0", busy, in_ready, mem_wen);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_ready = 1'b1;
        tests++; if (mem_wen !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL drain_reset got wen=%b busy=%b done=%b want 1/0/0", mem_wen, busy, done);
        end
        repeat (5) tick();
        tests++; if (wr_addr_q.size() != 0) begin fails++; $display("FAIL drain_no_write got %0d want 0", wr_addr_q.size()); end

        // start together with reset: reset wins.
        start = 1'b1; reset = 1'b1;
        tick();
        start = 1'b0; reset = 1'b0;
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_vs_start got busy=%b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_round_relu_sat();
        test_backpressure();
        test_wrap_freeze();
        test_boundary();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
